alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL: clk  input  1  single clock, all state rising-edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid / in_ready  input / output  1 / 1  decode-side handshake; transfer when both high.
REQ-004 SHALL: rs1_addr, rs2_addr, rd_addr  input  5 each  source and destination register indices.
REQ-005 SHALL: rs1_data, rs2_data, imm, pc  input  32 each  register-file operands, immediate, instruction PC.
REQ-006 SHALL: a_sel  input  2  A source: 0 = rs1, 1 = pc, 2 = zero, 3 = reserved (acts as zero).
REQ-007 SHALL: b_sel  input  2  B source: 0 = rs2, 1 = imm, 2 = constant 4, 3 = reserved (acts as zero).
REQ-008 SHALL: alu_op_in  input  4  ALU operation code; reg_wen_in  input  1  writeback enable.
REQ-009 SHALL: flush  input  1  kills the held entry and any same-cycle transfer.
REQ-010 SHALL: exm_rd, exm_wen, exm_is_load, exm_data  input  5/1/1/32  EX/MEM forwarding source.
REQ-011 SHALL: mwb_rd, mwb_wen, mwb_data  input  5/1/32  MEM/WB forwarding source.
REQ-012 SHALL: out_valid / out_ready  output / input  1 / 1  ALU-side handshake.
REQ-013 SHALL: alu_a, alu_b  output  32 each; alu_op  output  4; rd_out  output  5; reg_wen_out  output  1; rs2_fwd  output  32 (store data).

Function
REQ-014 SHALL: single-entry registered stage; latency exactly one cycle from accepted input to out_valid.
REQ-015 SHALL: in_ready = !out_valid || out_ready, masked low by a stall (REQ-019).
REQ-016 SHALL: operand selection and forwarding resolved before the register; alu_a/alu_b are register outputs, no combinational input-to-output path.
REQ-017 SHALL: forwarding per source: exm match wins over mwb match; match = wen high and rd equal to source index and index nonzero; x0 always reads 0.
REQ-018 SHALL: rs2_fwd carries forwarded rs2 regardless of b_sel.
REQ-019 SHALL: load-use stall: in_valid with exm_wen, exm_is_load, exm_rd nonzero and equal to a used source -> in_ready low, no capture; a source is used only if its a_sel/b_sel selects it, except rs2 always used when reg_wen_in is low.
REQ-020 SHALL: out_valid held, out_ready low -> all outputs stable; in_ready low.
REQ-021 SHALL: out_ready high, no new transfer -> next cycle out_valid low, alu_op = ALU_XXX, reg_wen_out low (bubble).
REQ-022 SHALL: flush has priority over every transfer: next cycle emits a bubble.
REQ-023 SHALL: reg_wen_out low whenever out_valid is low.

Reset
REQ-024 SHALL: rst_n low -> immediately out_valid 0, alu_a 0, alu_b 0, rs2_fwd 0, rd_out 0, reg_wen_out 0, alu_op ALU_XXX (4'b1111).
REQ-025 SHALL: reset mid-operation discards the held entry; first accept possible on the first edge after rst_n rises.

Configuration
REQ-026 SHALL: macro ALU_OPERAND_FWD_EN defined -> forwarding per REQ-017, stall only per REQ-019.
REQ-027 SHALL: macro absent -> no forwarding muxes; rs1_data/rs2_data used raw; stall whenever any used nonzero source matches exm_rd (exm_wen) or mwb_rd (mwb_wen).

Structure
REQ-028 SHALL: ALU op codes (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRA 1000, SRL 1001, COPY_B 1010, XXX 1111) and a_sel/b_sel encodings live in the shared ALU-op header, not redefined locally.
REQ-029 SHALL: one sub-module, fwd_mux, resolves one 32-bit source; instantiated twice.

Verification
REQ-030 SHALL: reset with inputs toggling -> out_valid 0, alu_op 4'b1111 until first accepted beat.
REQ-031 SHALL: rs1=5 (data 0x10), exm_rd=5 data 0xAA, mwb_rd=5 data 0xBB, a_sel 0 -> alu_a 0xAA next cycle (0x10 with macro off, after stall clears).
REQ-032 SHALL: exm_is_load, exm_rd=7, rs2=7, b_sel 0 -> in_ready low one cycle; with exm cleared, accepted; b_sel 1 instead -> no stall.
REQ-033 SHALL: rs1_addr 0 with exm_rd 0, exm_wen 1, data 0xFFFF_FFFF -> alu_a 0.
REQ-034 SHALL: a_sel 1, b_sel 2, pc 0x100, alu_op COPY_B -> alu_a 0x100, alu_b 4.
REQ-035 SHALL: out_ready low three cycles then flush -> outputs stable during hold, bubble the cycle after flush, new beat accepted next.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU-op header: operation codes, operand-select encodings and the
// register-match helper used by the operand stage and its forwarding muxes.
package alu_operand_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000,
      ALU_SUB    = 4'b0001,
      ALU_AND    = 4'b0010,
      ALU_OR     = 4'b0011,
      ALU_XOR    = 4'b0100,
      ALU_SLT    = 4'b0101,
      ALU_SLTU   = 4'b0110,
      ALU_SLL    = 4'b0111,
      ALU_SRA    = 4'b1000,
      ALU_SRL    = 4'b1001,
      ALU_COPY_B = 4'b1010,
      ALU_XXX    = 4'b1111
   } alu_op_e;

   localparam logic [1:0] A_SEL_RS1  = 2'd0;
   localparam logic [1:0] A_SEL_PC   = 2'd1;
   localparam logic [1:0] A_SEL_ZERO = 2'd2;

   localparam logic [1:0] B_SEL_RS2  = 2'd0;
   localparam logic [1:0] B_SEL_IMM  = 2'd1;
   localparam logic [1:0] B_SEL_FOUR = 2'd2;

   localparam logic [31:0] CONST_FOUR = 32'd4;

   // A writer only matches a source when it actually writes a real register.
   function automatic logic src_match(input logic [4:0] src,
                                      input logic [4:0] rd,
                                      input logic       wen);
      return wen && (rd != 5'd0) && (rd == src);
   endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one 32-bit source operand; x0 always reads zero.
// Forwarding from EX/MEM and MEM/WB only exists when ALU_OPERAND_FWD_EN is defined.
module fwd_mux
   import alu_operand_stage_pkg::*;
(
   input  logic [4:0]  src_addr,
   input  logic [31:0] reg_data,
   input  logic [4:0]  exm_rd,
   input  logic        exm_wen,
   input  logic [31:0] exm_data,
   input  logic [4:0]  mwb_rd,
   input  logic        mwb_wen,
   input  logic [31:0] mwb_data,
   output logic [31:0] fwd_data
);

   // The younger EX/MEM result shadows the older MEM/WB one.
   always_comb begin
      fwd_data = reg_data;
      if (src_addr == 5'd0)
         fwd_data = '0;
`ifdef ALU_OPERAND_FWD_EN
      else if (src_match(src_addr, exm_rd, exm_wen))
         fwd_data = exm_data;
      else if (src_match(src_addr, mwb_rd, mwb_wen))
         fwd_data = mwb_data;
`endif
   end

`ifndef ALU_OPERAND_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{exm_rd, exm_wen, exm_data, mwb_rd, mwb_wen, mwb_data};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry operand stage between decode and the ALU, with hazard stall.
// Define ALU_OPERAND_FWD_EN for forwarding; otherwise any pending write stalls.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [31:0] pc,
   input  logic [1:0]  a_sel,
   input  logic [1:0]  b_sel,
   input  logic [3:0]  alu_op_in,
   input  logic        reg_wen_in,
   input  logic        flush,
   input  logic [4:0]  exm_rd,
   input  logic        exm_wen,
   input  logic        exm_is_load,
   input  logic [31:0] exm_data,
   input  logic [4:0]  mwb_rd,
   input  logic        mwb_wen,
   input  logic [31:0] mwb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic [4:0]  rd_out,
   output logic        reg_wen_out,
   output logic [31:0] rs2_fwd
);

   logic [31:0] rs1_resolved;
   logic [31:0] rs2_resolved;
   logic [31:0] a_next;
   logic [31:0] b_next;
   logic        rs1_used;
   logic        rs2_used;
   logic        rs1_hazard;
   logic        rs2_hazard;
   logic        stall;
   logic        transfer;

   fwd_mux u_fwd_rs1 (
      .src_addr (rs1_addr),
      .reg_data (rs1_data),
      .exm_rd   (exm_rd),
      .exm_wen  (exm_wen),
      .exm_data (exm_data),
      .mwb_rd   (mwb_rd),
      .mwb_wen  (mwb_wen),
      .mwb_data (mwb_data),
      .fwd_data (rs1_resolved)
   );

   fwd_mux u_fwd_rs2 (
      .src_addr (rs2_addr),
      .reg_data (rs2_data),
      .exm_rd   (exm_rd),
      .exm_wen  (exm_wen),
      .exm_data (exm_data),
      .mwb_rd   (mwb_rd),
      .mwb_wen  (mwb_wen),
      .mwb_data (mwb_data),
      .fwd_data (rs2_resolved)
   );

   // Stores (no writeback) always need rs2 as store data, whatever b_sel says.
   assign rs1_used = (a_sel == A_SEL_RS1);
   assign rs2_used = (b_sel == B_SEL_RS2) || !reg_wen_in;

`ifdef ALU_OPERAND_FWD_EN
   assign rs1_hazard = exm_is_load && src_match(rs1_addr, exm_rd, exm_wen);
   assign rs2_hazard = exm_is_load && src_match(rs2_addr, exm_rd, exm_wen);
`else
   assign rs1_hazard = src_match(rs1_addr, exm_rd, exm_wen) ||
                       src_match(rs1_addr, mwb_rd, mwb_wen);
   assign rs2_hazard = src_match(rs2_addr, exm_rd, exm_wen) ||
                       src_match(rs2_addr, mwb_rd, mwb_wen);
   logic unused_top;
   assign unused_top = exm_is_load;
`endif

   assign stall    = in_valid && ((rs1_used && rs1_hazard) || (rs2_used && rs2_hazard));
   assign in_ready = (!out_valid || out_ready) && !stall;
   assign transfer = in_valid && in_ready;

   always_comb begin
      a_next = '0;
      case (a_sel)
         A_SEL_RS1: a_next = rs1_resolved;
         A_SEL_PC:  a_next = pc;
         default:   a_next = '0;
      endcase
   end

   always_comb begin
      b_next = '0;
      case (b_sel)
         B_SEL_RS2:  b_next = rs2_resolved;
         B_SEL_IMM:  b_next = imm;
         B_SEL_FOUR: b_next = CONST_FOUR;
         default:    b_next = '0;
      endcase
   end

   // Flush beats any transfer; a drained entry leaves a bubble behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= ALU_XXX;
         rd_out      <= '0;
         reg_wen_out <= 1'b0;
         rs2_fwd     <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         alu_op      <= ALU_XXX;
         reg_wen_out <= 1'b0;
      end else if (transfer) begin
         out_valid   <= 1'b1;
         alu_a       <= a_next;
         alu_b       <= b_next;
         alu_op      <= alu_op_in;
         rd_out      <= rd_addr;
         reg_wen_out <= reg_wen_in;
         rs2_fwd     <= rs2_resolved;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
         alu_op      <= ALU_XXX;
         reg_wen_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow ALU_OPERAND_FWD_EN.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, imm, pc;
   logic [1:0]  a_sel, b_sel;
   logic [3:0]  alu_op_in;
   logic        reg_wen_in, flush;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_wen, exm_is_load, mwb_wen;
   logic [31:0] exm_data, mwb_data;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, rs2_fwd;
   logic [3:0]  alu_op;
   logic [4:0]  rd_out;
   logic        reg_wen_out;

   int testCount = 0;
   int failCount = 0;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
      .a_sel(a_sel), .b_sel(b_sel), .alu_op_in(alu_op_in), .reg_wen_in(reg_wen_in),
      .flush(flush), .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_is_load(exm_is_load),
      .exm_data(exm_data), .mwb_rd(mwb_rd), .mwb_wen(mwb_wen), .mwb_data(mwb_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .rd_out(rd_out), .reg_wen_out(reg_wen_out), .rs2_fwd(rs2_fwd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] as, input logic [1:0] bs,
                                input logic [3:0] op, input logic [4:0] rd, input logic wen);
      in_valid   = v;
      a_sel      = as;
      b_sel      = bs;
      alu_op_in  = op;
      rd_addr    = rd;
      reg_wen_in = wen;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, "_op"}, {28'd0, alu_op}, {28'd0, ALU_XXX});
      checkOutput({tag, "_wen"}, {31'd0, reg_wen_out}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0; out_ready = 1'b1;
      rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
      exm_rd = '0; exm_wen = 1'b0; exm_is_load = 1'b0; exm_data = '0;
      mwb_rd = '0; mwb_wen = 1'b0; mwb_data = '0;
      applyStimulus(1'b0, A_SEL_RS1, B_SEL_RS2, ALU_ADD, 5'd0, 1'b0);

      // Reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], A_SEL_PC, B_SEL_IMM, ALU_SUB, 5'd1, 1'b1);
         pc = 32'h1000 + i;
         stepCycle();
         checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
         checkOutput("rst_op", {28'd0, alu_op}, {28'd0, ALU_XXX});
      end
      checkOutput("rst_alu_a", alu_a, 32'd0);
      checkOutput("rst_rd", {27'd0, rd_out}, 32'd0);
      checkOutput("rst_wen", {31'd0, reg_wen_out}, 32'd0);
      rst_n = 1'b1;

      // PC plus constant four, COPY_B
      pc = 32'h100;
      applyStimulus(1'b1, A_SEL_PC, B_SEL_FOUR, ALU_COPY_B, 5'd3, 1'b1);
      #1;
      checkOutput("copyb_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("copyb_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("copyb_a", alu_a, 32'h100);
      checkOutput("copyb_b", alu_b, 32'd4);
      checkOutput("copyb_op", {28'd0, alu_op}, {28'd0, ALU_COPY_B});
      checkOutput("copyb_rd", {27'd0, rd_out}, 32'd3);
      checkOutput("copyb_wen", {31'd0, reg_wen_out}, 32'd1);

      applyStimulus(1'b0, A_SEL_PC, B_SEL_FOUR, ALU_COPY_B, 5'd3, 1'b1);
      stepCycle();
      checkBubble("drain");

      // rs1 matches both EX/MEM and MEM/WB
      rs1_addr = 5'd5; rs1_data = 32'h10; rs2_addr = 5'd0; imm = 32'h22;
      exm_rd = 5'd5; exm_wen = 1'b1; exm_data = 32'hAA;
      mwb_rd = 5'd5; mwb_wen = 1'b1; mwb_data = 32'hBB;
      applyStimulus(1'b1, A_SEL_RS1, B_SEL_IMM, ALU_ADD, 5'd8, 1'b1);
      #1;
`ifdef ALU_OPERAND_FWD_EN
      checkOutput("fwd1_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("fwd1_a", alu_a, 32'hAA);
`else
      checkOutput("fwd1_stall", {31'd0, in_ready}, 32'd0);
      stepCycle();
      checkOutput("fwd1_stall_valid", {31'd0, out_valid}, 32'd0);
      exm_wen = 1'b0; mwb_wen = 1'b0;
      #1;
      checkOutput("fwd1_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("fwd1_a", alu_a, 32'h10);
`endif
      checkOutput("fwd1_b", alu_b, 32'h22);

      // rs2 matches only MEM/WB
      rs1_addr = 5'd0; rs2_addr = 5'd6; rs2_data = 32'h60;
      exm_rd = 5'd5; exm_wen = 1'b1; mwb_rd = 5'd6; mwb_wen = 1'b1;
      applyStimulus(1'b1, A_SEL_ZERO, B_SEL_RS2, ALU_ADD, 5'd8, 1'b1);
`ifdef ALU_OPERAND_FWD_EN
      stepCycle();
      checkOutput("fwd2_b", alu_b, 32'hBB);
      checkOutput("fwd2_store", rs2_fwd, 32'hBB);
`else
      stepCycle();
      checkOutput("fwd2_stall_valid", {31'd0, out_valid}, 32'd0);
      exm_wen = 1'b0; mwb_wen = 1'b0;
      stepCycle();
      checkOutput("fwd2_b", alu_b, 32'h60);
      checkOutput("fwd2_store", rs2_fwd, 32'h60);
`endif
      checkOutput("fwd2_a", alu_a, 32'd0);

      // Load-use on rs2
      mwb_wen = 1'b0;
      exm_rd = 5'd7; exm_wen = 1'b1; exm_is_load = 1'b1; exm_data = 32'hDD;
      rs2_addr = 5'd7; rs2_data = 32'h77; imm = 32'h44;
      applyStimulus(1'b1, A_SEL_ZERO, B_SEL_RS2, ALU_SUB, 5'd2, 1'b1);
      #1;
      checkOutput("ld_stall", {31'd0, in_ready}, 32'd0);
      stepCycle();
      checkOutput("ld_stall_valid", {31'd0, out_valid}, 32'd0);
      exm_wen = 1'b0;
      #1;
      checkOutput("ld_clear_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("ld_clear_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("ld_clear_b", alu_b, 32'h77);
      exm_wen = 1'b1;
      applyStimulus(1'b1, A_SEL_ZERO, B_SEL_IMM, ALU_ADD, 5'd2, 1'b1);
      #1;
      checkOutput("ld_imm_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("ld_imm_b", alu_b, 32'h44);
`ifdef ALU_OPERAND_FWD_EN
      checkOutput("ld_imm_store", rs2_fwd, 32'hDD);
`else
      checkOutput("ld_imm_store", rs2_fwd, 32'h77);
`endif
      applyStimulus(1'b1, A_SEL_ZERO, B_SEL_IMM, ALU_ADD, 5'd0, 1'b0);
      #1;
      checkOutput("ld_store_stall", {31'd0, in_ready}, 32'd0);

      // x0 never forwards
      exm_is_load = 1'b0; exm_rd = 5'd0; exm_wen = 1'b1; exm_data = 32'hFFFF_FFFF;
      rs1_addr = 5'd0; rs1_data = 32'h1234; rs2_addr = 5'd0; imm = 32'h55;
      applyStimulus(1'b1, A_SEL_RS1, B_SEL_IMM, ALU_ADD, 5'd4, 1'b1);
      #1;
      checkOutput("x0_ready", {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput("x0_a", alu_a, 32'd0);

      // Hold under backpressure, then flush
      exm_wen = 1'b0;
      pc = 32'h200; imm = 32'h33;
      applyStimulus(1'b1, A_SEL_PC, B_SEL_IMM, ALU_ADD, 5'd9, 1'b1);
      stepCycle();
      checkOutput("hold_load_a", alu_a, 32'h200);
      out_ready = 1'b0;
      pc = 32'h300; imm = 32'h66;
      applyStimulus(1'b1, A_SEL_PC, B_SEL_IMM, ALU_SUB, 5'd10, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("hold_ready", {31'd0, in_ready}, 32'd0);
         stepCycle();
         checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("hold_a", alu_a, 32'h200);
         checkOutput("hold_b", alu_b, 32'h33);
         checkOutput("hold_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
         checkOutput("hold_rd", {27'd0, rd_out}, 32'd9);
      end
      flush = 1'b1; out_ready = 1'b1;
      stepCycle();
      checkBubble("flush");
      flush = 1'b0;
      stepCycle();
      checkOutput("post_flush_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("post_flush_a", alu_a, 32'h300);
      checkOutput("post_flush_op", {28'd0, alu_op}, {28'd0, ALU_SUB});

      // Reset mid-operation
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_a", alu_a, 32'd0);
      checkOutput("midrst_op", {28'd0, alu_op}, {28'd0, ALU_XXX});
      checkOutput("midrst_store", rs2_fwd, 32'd0);
      #3;
      rst_n = 1'b1;
      pc = 32'h400;
      applyStimulus(1'b1, A_SEL_PC, B_SEL_FOUR, ALU_ADD, 5'd11, 1'b1);
      stepCycle();
      checkOutput("rst_accept_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("rst_accept_a", alu_a, 32'h400);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
